clock_output_divider: RTL and testbench

CLOCK_OUTPUT_DIVIDER -- requirements
Module: clock_output_divider

---
 rtl/clock_output_divider.sv | 130 +++++++++++++
 tb/tb_clock_output_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clock_output_divider.sv
// Forwarded-clock generator: divides CLK by a runtime divisor N.
// Start/stop at period boundaries, divisor changes deferred to boundaries.
`timescale 1ns/1ps
module clock_output_divider #(
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN_start,
    input  logic                 EN_stop,
    input  logic                 EN_setDivisor,
    input  logic [DIV_WIDTH-1:0] setDivisor_div,
    output logic                 RDY_setDivisor,
    output logic                 CLK_OUT,
    output logic                 CLK_GATE_OUT,
    output logic                 RISE_PULSE
);

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                 pend_q, pend_d;
    logic                 clk_out_q, clk_out_d;
    logic                 gate_q, gate_d;
    logic                 rise_q, rise_d;
    logic                 rdy_q, rdy_d;

    logic [DIV_WIDTH-1:0] wr_div;
    logic                 wr_acc;
    logic                 boundary;
    logic                 run_d;

    always_comb begin
        wr_div     = (setDivisor_div < MIN_DIV) ? MIN_DIV : setDivisor_div;
        wr_acc     = EN_setDivisor && rdy_q;
        boundary   = (cnt_q == (div_q - ONE));
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        unique case (state_q)
            STOPPED: begin
                if (wr_acc) begin
                    div_d = wr_div;
                end
                if (EN_start && !EN_stop) begin
                    state_d = RUNNING;
                    cnt_d   = '0;
                end
            end
            RUNNING, STOPPING: begin
                if (EN_stop) begin
                    state_d = STOPPING;
                end else if (EN_start) begin
                    state_d = RUNNING;
                end
                cnt_d = boundary ? '0 : cnt_q + ONE;
                if (boundary && pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
                if (boundary && state_d == STOPPING) begin
                    state_d = STOPPED;
                    cnt_d   = '0;
                end
                // A write landing as we drop to STOPPED can apply directly
                if (wr_acc) begin
                    if (state_d == STOPPED) begin
                        div_d = wr_div;
                    end else begin
                        pend_d     = 1'b1;
                        pend_div_d = wr_div;
                    end
                end
            end
            default: begin
                state_d = STOPPED;
                cnt_d   = '0;
            end
        endcase
        run_d     = (state_d != STOPPED);
        rdy_d     = !pend_d;
        gate_d    = run_d;
        clk_out_d = run_d && (cnt_d < (div_d >> 1));
        rise_d    = run_d && (cnt_d == '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= STOPPED;
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            gate_q     <= 1'b0;
            rise_q     <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            gate_q     <= gate_d;
            rise_q     <= rise_d;
            rdy_q      <= rdy_d;
        end
    end

    assign RDY_setDivisor = rdy_q;
    assign CLK_OUT        = clk_out_q;
    assign CLK_GATE_OUT   = gate_q;
    assign RISE_PULSE     = rise_q;

endmodule

// File: tb/tb_clock_output_divider.sv
// Scoreboard bench for clock_output_divider.
// Each cycle code is hex {CLK_OUT, CLK_GATE_OUT, RISE_PULSE, RDY_setDivisor}.
`timescale 1ns/1ps
module tb_clock_output_divider;

    logic       CLK;
    logic       RST_N;
    logic       EN_start;
    logic       EN_stop;
    logic       EN_setDivisor;
    logic [7:0] setDivisor_div;
    logic       RDY_setDivisor;
    logic       CLK_OUT;
    logic       CLK_GATE_OUT;
    logic       RISE_PULSE;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    clock_output_divider dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .EN_start       (EN_start),
        .EN_stop        (EN_stop),
        .EN_setDivisor  (EN_setDivisor),
        .setDivisor_div (setDivisor_div),
        .RDY_setDivisor (RDY_setDivisor),
        .CLK_OUT        (CLK_OUT),
        .CLK_GATE_OUT   (CLK_GATE_OUT),
        .RISE_PULSE     (RISE_PULSE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [3:0] outs();
        return {CLK_OUT, CLK_GATE_OUT, RISE_PULSE, RDY_setDivisor};
    endfunction

    function automatic logic [3:0] hexc(input byte c);
        if (c >= "A") return 4'(c - 8'd55);
        return 4'(c - 8'd48);
    endfunction

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {clk,gate,rise,rdy}=%b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, outs(), e.exp);
            end
        end
    end

    task automatic step(input logic st, input logic sp, input logic wr,
                        input logic [7:0] d, input byte code,
                        input string name);
        exp_t e;
        EN_start       = st;
        EN_stop        = sp;
        EN_setDivisor  = wr;
        setDivisor_div = d;
        @(posedge CLK);
        #1;
        e.exp  = hexc(code);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic wave(input string w, input string name);
        for (int i = 0; i < w.len(); i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0, w[i], name);
        end
    endtask

    initial begin
        exp_t e;
        EN_start       = 1'b0;
        EN_stop        = 1'b0;
        EN_setDivisor  = 1'b0;
        setDivisor_div = 8'd0;
        RST_N          = 1'b1;
        #1 RST_N = 1'b0;
        step(0, 0, 0, 8'd0, "1", "reset_state");
        step(0, 0, 0, 8'd0, "1", "reset_state");
        RST_N = 1'b1;

        step(1, 0, 0, 8'd0, "F", "n2_start");
        wave("5F5F", "n2_run");
        step(0, 1, 0, 8'd0, "5", "n2_stop");
        wave("11", "n2_stopped");

        step(0, 0, 1, 8'd5, "1", "n5_write");
        step(1, 0, 0, 8'd0, "F", "n5_start");
        wave("D555FD555F", "n5_run");
        step(0, 1, 0, 8'd0, "D", "n5_stop");
        wave("5551", "n5_stopping");

        step(0, 0, 1, 8'd1, "1", "n1_write");
        step(1, 0, 0, 8'd0, "F", "n1_start");
        wave("5F5F", "n1_clamped");
        step(0, 1, 0, 8'd0, "5", "n1_stop");
        wave("1", "n1_stopped");

        step(0, 0, 1, 8'd4, "1", "n4_write");
        step(1, 0, 0, 8'd0, "F", "n4_start");
        wave("D55F", "n4_run");
        step(0, 0, 1, 8'd7, "C", "n7_write_mid");
        step(0, 0, 1, 8'd3, "4", "drop_write_rdy_low");
        wave("4FDD5555", "n7_applied");
        step(0, 0, 1, 8'd2, "E", "write_on_boundary");
        wave("CC4444F5F", "boundary_write_deferred");
        step(0, 1, 0, 8'd0, "5", "n2b_stop");
        wave("1", "n2b_stopped");

        step(0, 0, 1, 8'd6, "1", "n6_write");
        step(1, 0, 0, 8'd0, "F", "n6_start");
        step(0, 1, 0, 8'd0, "D", "n6_stop_c1");
        wave("D5551", "n6_stopping");
        step(1, 0, 0, 8'd0, "F", "n6_restart");
        wave("DD555F", "n6_run");
        step(0, 1, 0, 8'd0, "D", "n6_stop2");
        wave("D", "n6_stopping2");
        step(1, 0, 0, 8'd0, "5", "cancel_stop");
        wave("55FDD555F", "cancel_uninterrupted");
        step(1, 1, 0, 8'd0, "D", "both_running");
        wave("D5551", "both_running_stops");
        step(1, 1, 0, 8'd0, "1", "both_stopped");
        wave("1", "both_stopped_stays");

        step(1, 0, 0, 8'd0, "F", "pre_rst_start");
        step(0, 0, 1, 8'd9, "C", "n9_pending");
        wave("C", "n9_high_phase");
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_immediate", outs(), 4'h1);
        e.exp  = 4'h1;
        e.name = "reset_held";
        q.push_back(e);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        step(1, 0, 0, 8'd0, "F", "post_rst_start");
        wave("5F5F", "post_rst_div2");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
